// File: rtl/arbitro_destino.sv
// Destination arbiter: drains four class FIFOs and routes each word to a destination FIFO.
// Define ARB_RR_EN for round-robin class arbitration; the default is strict priority (class 3 highest).
module arbitro_destino #(
  parameter int WORD_SIZE = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*WORD_SIZE-1:0] data_in,
  input  logic [3:0]             fifos_empty,
  input  logic [3:0]             fifos_almost_full,
  output logic [3:0]             pop,
  output logic [3:0]             push,
  output logic [WORD_SIZE-1:0]   data_out_arb,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [3:0]           pop_q, pop_d;
  logic [3:0]           push_q, push_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic [3:0]           eligible_s;
  logic [1:0]           sel_s;
  logic [WORD_SIZE-1:0] word_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

`ifdef ARB_RR_EN
  logic [1:0] last_q, last_d;

  // Round-robin: first eligible class after the last grant, wrapping.
  function automatic logic [1:0] select_class(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    select_class = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (elig[idx]) begin
        select_class = idx;
      end else begin
        select_class = select_class;
      end
    end
  endfunction

  assign sel_s = select_class(eligible_s, last_q);
`else
  function automatic logic [1:0] select_class(input logic [3:0] elig);
    if (elig[3])      select_class = 2'd3;
    else if (elig[2]) select_class = 2'd2;
    else if (elig[1]) select_class = 2'd1;
    else              select_class = 2'd0;
  endfunction

  assign sel_s = select_class(eligible_s);
`endif

  // Any almost-full destination stalls all classes.
  assign eligible_s = (fifos_almost_full == 4'b0000) ? ~fifos_empty : 4'b0000;
  assign word_s     = data_in[int'(grant_q)*WORD_SIZE +: WORD_SIZE];

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pop_d   = 4'b0000;
    push_d  = 4'b0000;
    data_d  = '0;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (eligible_s != 4'b0000) begin
          grant_d = sel_s;
          pop_d   = onehot(sel_s);
          state_d = POP;
`ifdef ARB_RR_EN
          last_d  = sel_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = word_s;
        push_d  = onehot(word_s[WORD_SIZE-3:WORD_SIZE-4]);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      pop_q   <= 4'b0000;
      push_q  <= 4'b0000;
      data_q  <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign pop          = pop_q;
  assign push         = push_q;
  assign data_out_arb = data_q;
  assign busy         = busy_q;

endmodule
